// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and a valid/ready byte output.
// Optional macro UART_RX_MAJORITY_EN: each sample decision uses a 3-sample majority vote.
module uart_rx #(
  parameter int N_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [11:0] BIT_LAST  = 12'(N_CYCLES - 1);
  localparam logic [11:0] HALF_LAST = 12'(N_CYCLES / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] n_clks_q, n_clks_d;
  logic [2:0]  n_bits_q, n_bits_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic        samp;
  logic        stop_ok;
  logic        bit_tick;
  logic        mid_tick;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous synchronized values; together with rx_s_q they form the vote window.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], rx_s_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign samp = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rx_s_q;
`endif

  assign bit_tick = (n_clks_q == BIT_LAST);
  assign mid_tick = (n_clks_q == HALF_LAST);

  always_comb begin
    state_d     = state_q;
    n_clks_d    = n_clks_q + 12'd1;
    n_bits_d    = n_bits_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    stop_ok     = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        n_clks_d = 12'd0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (mid_tick) begin
          n_clks_d = 12'd0;
          n_bits_d = 3'd0;
          state_d  = samp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        // Counter restarts at start-bit mid, so every tick here lands mid-bit.
        if (bit_tick) begin
          n_clks_d          = 12'd0;
          shreg_d[n_bits_q] = samp;
          if (n_bits_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            n_bits_d = n_bits_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          n_clks_d = 12'd0;
          if (samp) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        n_clks_d = 12'd0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        n_clks_d = 12'd0;
        state_d  = S_IDLE;
      end
    endcase

    // A held byte may be replaced only if it is being accepted in this same cycle.
    if (stop_ok) begin
      if (!valid_q || ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      n_clks_q    <= 12'd0;
      n_bits_q    <= 3'd0;
      shreg_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      n_clks_q    <= n_clks_d;
      n_bits_q    <= n_bits_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized byte stream
// compared against a frame-level reference model.
module tb_uart_rx;

  localparam int N = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.N_CYCLES(N)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int failures = 0;

  // Event monitor, sampled on the falling edge.
  int          vld_rises = 0;
  int          fe_cnt = 0;
  int          ovr_cnt = 0;
  int          both_cnt = 0;
  int          hold_viol = 0;
  int unsigned rise_cyc = 0;
  logic [7:0]  acc_q[$];
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  always @(negedge clock) begin
    if (valid && !pv) begin
      vld_rises++;
      rise_cyc = cyc;
    end
    if (valid && ready) acc_q.push_back(data);
    if (frame_err) fe_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (pv && !pr && valid && (data !== pd)) hold_viol++;
    pv = valid;
    pr = ready;
    pd = data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One 8N1 frame, N cycles per bit; optional one-cycle inversion at (gbit, gpos).
  // rx is left at the stop-bit level afterwards.
  task automatic send(input logic [7:0] b, input logic stop = 1'b1,
                      input int gbit = -1, input int gpos = 0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < N; j++) begin
        rx = (i == gbit && j == gpos) ? ~fr[i] : fr[i];
        tick(1);
      end
    end
    rx = fr[9];
  endtask

  task automatic accept();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  // Reference: each bit is judged at its middle cycle; with majority voting the
  // two cycles before the middle also vote, so a lone flipped cycle cannot win.
  function automatic logic [7:0] model_rx(input logic [7:0] b, input int gbit, input int gpos);
    logic [7:0] r;
    int hits;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (gbit == i + 1) begin
        if (MAJ) hits = (gpos >= N / 2 - 2 && gpos <= N / 2) ? 1 : 0;
        else     hits = (gpos == N / 2) ? 1 : 0;
        if ((MAJ && hits >= 2) || (!MAJ && hits == 1)) r[i] = ~r[i];
      end
    end
    return r;
  endfunction

  initial begin
    int r0, f0, o0;
    int unsigned c0;
    int lat;
    int exp_lat;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    // Reset state
    tick(3);
    chk("reset_valid", valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_data", data, 8'h00);
    reset_n = 1'b1;
    tick(5);

    // Reset in the middle of a frame
    r0 = vld_rises;
    rx = 1'b0;
    tick(3 * N);
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_data", data, 8'h00);
    tick(2);
    rx = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(12 * N);
    chk("midreset_no_byte", vld_rises - r0, 0);
    chk("midreset_frame_err", frame_err, 1'b0);
    chk("midreset_overrun", overrun, 1'b0);
    send(8'h5A);
    chk("after_reset_valid", valid, 1'b1);
    chk("after_reset_data", data, model_rx(8'h5A, -1, 0));
    accept();
    chk("after_reset_cleared", valid, 1'b0);

    // Single byte, latency and hold
    c0 = cyc;
    send(8'hA5);
    lat = int'(rise_cyc - c0);
    exp_lat = 2 + N / 2 + 9 * N + 1;
    chk("latency_window", (lat >= exp_lat - 1 && lat <= exp_lat + 1), 1'b1);
    tick(50);
    chk("hold_valid", valid, 1'b1);
    chk("hold_data", data, 8'hA5);
    accept();
    chk("ready_clears_valid", valid, 1'b0);

    // Start glitch rejected
    r0 = vld_rises;
    f0 = fe_cnt;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * N);
    chk("glitch_no_valid", vld_rises - r0, 0);
    chk("glitch_no_frame_err", fe_cnt - f0, 0);
    send(8'h3C);
    chk("post_glitch_data", data, 8'h3C);
    accept();

    // Framing error then break, then a good frame
    r0 = vld_rises;
    f0 = fe_cnt;
    o0 = ovr_cnt;
    send(8'h3C, 1'b0);
    tick(40);
    chk("frame_err_pulse", fe_cnt - f0, 1);
    chk("frame_bad_no_valid", valid, 1'b0);
    rx = 1'b1;
    tick(N);
    send(8'h55);
    chk("frame_next_data", data, 8'h55);
    chk("frame_next_valid_once", vld_rises - r0, 1);
    chk("frame_err_single", fe_cnt - f0, 1);
    chk("frame_no_overrun", ovr_cnt - o0, 0);
    accept();

    // Overrun on back-to-back frames with no consumer
    f0 = fe_cnt;
    o0 = ovr_cnt;
    send(8'h11);
    send(8'h22);
    tick(5);
    chk("overrun_kept_data", data, 8'h11);
    chk("overrun_kept_valid", valid, 1'b1);
    chk("overrun_pulse", ovr_cnt - o0, 1);
    chk("overrun_no_frame_err", fe_cnt - f0, 0);
    accept();
    chk("overrun_cleared", valid, 1'b0);

    // Back-to-back streaming with ready held
    ready = 1'b1;
    acc_q.delete();
    r0 = vld_rises;
    f0 = fe_cnt;
    o0 = ovr_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h80);
    tick(5);
    chk("stream_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("stream_b0", acc_q[0], 8'h00);
      chk("stream_b1", acc_q[1], 8'hFF);
      chk("stream_b2", acc_q[2], 8'h80);
    end
    chk("stream_rises", vld_rises - r0, 3);
    chk("stream_no_flags", (fe_cnt - f0) + (ovr_cnt - o0), 0);
    ready = 1'b0;

    // One-cycle glitch exactly at the bit-2 sample instant
    send(8'h0F, 1'b1, 3, N / 2);
    chk("sample_glitch_data", data, model_rx(8'h0F, 3, N / 2));
    accept();

    // Randomized stream with random idle gaps
    ready = 1'b1;
    acc_q.delete();
    f0 = fe_cnt;
    o0 = ovr_cnt;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      exp_q.push_back(model_rx(b, -1, 0));
      send(b);
      tick($urandom_range(0, 2 * N));
    end
    tick(5);
    chk("rand_count", acc_q.size(), exp_q.size());
    for (int k = 0; k < 16; k++) begin
      if (k < acc_q.size()) chk($sformatf("rand_byte%0d", k), acc_q[k], exp_q[k]);
    end
    chk("rand_no_flags", (fe_cnt - f0) + (ovr_cnt - o0), 0);
    ready = 1'b0;

    chk("flags_exclusive", both_cnt, 0);
    chk("data_stable_while_held", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
